// File: rtl/ser_word_collector_pkg.sv
// Shared definitions for the serial-to-word path: default sizing and output-register states.
package ser_word_collector_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultCntW  = 5;

  // A bit counter of cnt_w bits can hold every index 0..width-1.
  function automatic bit cnt_w_fits(input int unsigned width, input int unsigned cnt_w);
    return (64'd1 << cnt_w) >= 64'(width);
  endfunction

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } out_state_e;

endpackage

// File: rtl/ser_bit_counter.sv
// Mod-WIDTH bit counter; clr wins over inc, rst wins over everything.
module ser_bit_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: abort to zero, wrap after the final bit, otherwise step.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == LastCnt);

endmodule

// File: rtl/ser_word_collector.sv
// Packs a handshaked serial bit stream into WIDTH-bit words with a one-word output register.
module ser_word_collector
  import ser_word_collector_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = DefaultCntW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             sin,
  input  logic             sin_valid,
  output logic             sin_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy
);

  logic [WIDTH-1:0] sr_q, sr_d, sr_shift;
  logic [WIDTH-1:0] dout_q, dout_d;
  out_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             accept;
  logic             word_done;

  assign dout_valid = (state_q == StFull);
  // Stall only when the final bit would overwrite a word nobody has taken yet.
  assign sin_ready  = !(last && dout_valid && !dout_ready);
  // A bit offered during clr is dropped.
  assign accept     = sin_valid && sin_ready && !clr;
  assign word_done  = accept && last;
  assign busy       = (cnt != '0);
  assign dout       = dout_q;

  ser_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (accept),
    .clr  (clr),
    .cnt  (cnt),
    .last (last)
  );

  // Shifted value including the current bit, in the configured arrival order.
  always_comb begin
    if (MSB_FIRST) begin
      sr_shift = {sr_q[WIDTH-2:0], sin};
    end else begin
      sr_shift = {sin, sr_q[WIDTH-1:1]};
    end
  end

  // Next-state for shift register and output register.
  always_comb begin
    sr_d    = sr_q;
    dout_d  = dout_q;
    state_d = state_q;
    if (clr) begin
      sr_d = '0;
    end else if (accept) begin
      sr_d = sr_shift;
    end
    if (word_done) begin
      // A completing word reloads dout even when the held word leaves this cycle.
      dout_d  = sr_shift;
      state_d = StFull;
    end else if (state_q == StFull && dout_ready) begin
      state_d = StEmpty;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q    <= '0;
      dout_q  <= '0;
      state_q <= StEmpty;
    end else begin
      sr_q    <= sr_d;
      dout_q  <= dout_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_ser_word_collector.sv
// Drives an MSB-first and an LSB-first collector with identical inputs and checks both
// against a word-level reference model every cycle.
module tb_ser_word_collector;

  localparam int W = 8;

  logic         clk;
  logic         rst, clr, sin, sin_valid, dout_ready;
  logic         sin_ready_m, dout_valid_m, busy_m;
  logic         sin_ready_l, dout_valid_l, busy_l;
  logic [W-1:0] dout_m, dout_l;

  int n_total, n_bad;

  // Reference model state.
  int m_n, acc_m, acc_l, md_m, md_l;
  bit m_valid, m_known;

  // Observations from the most recent cycle.
  bit obs_ready, last_acc;
  int vcount, stall_count;

  ser_word_collector #(.WIDTH(W), .MSB_FIRST(1'b1), .CNT_W(5)) u_msb (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_ready  (sin_ready_m),
    .dout       (dout_m),
    .dout_valid (dout_valid_m),
    .dout_ready (dout_ready),
    .busy       (busy_m)
  );

  ser_word_collector #(.WIDTH(W), .MSB_FIRST(1'b0), .CNT_W(5)) u_lsb (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_ready  (sin_ready_l),
    .dout       (dout_l),
    .dout_valid (dout_valid_l),
    .dout_ready (dout_ready),
    .busy       (busy_l)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, check outputs 1 time unit later, advance the model at posedge.
  task automatic cycle(input logic r, input logic c, input logic v, input logic s,
                       input logic dr);
    bit exp_ready;
    rst = r; clr = c; sin_valid = v; sin = s; dout_ready = dr;
    #1;
    exp_ready = !(m_n == W - 1 && m_valid && !dr);
    if (m_known) begin
      check_eq("ready_m", sin_ready_m, exp_ready);
      check_eq("ready_l", sin_ready_l, exp_ready);
      check_eq("valid_m", dout_valid_m, m_valid);
      check_eq("valid_l", dout_valid_l, m_valid);
      check_eq("busy_m", busy_m, m_n != 0);
      check_eq("busy_l", busy_l, m_n != 0);
      check_eq("dout_m", dout_m, md_m);
      check_eq("dout_l", dout_l, md_l);
    end
    obs_ready = sin_ready_m;
    if (dout_valid_m) vcount++;
    if (!sin_ready_m) stall_count++;
    last_acc = v && exp_ready && !c && !r;
    @(posedge clk);
    if (r) begin
      m_n = 0; acc_m = 0; acc_l = 0; md_m = 0; md_l = 0; m_valid = 0; m_known = 1;
    end else begin
      if (m_valid && dr) m_valid = 0;
      if (c) begin
        m_n = 0; acc_m = 0; acc_l = 0;
      end else if (last_acc) begin
        acc_m = ((acc_m * 2) + int'(s)) % 256;
        acc_l = acc_l + (int'(s) << m_n);
        m_n++;
        if (m_n == W) begin
          md_m = acc_m; md_l = acc_l; m_valid = 1;
          m_n = 0; acc_m = 0; acc_l = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  // Offers the bits of w, w[7] first, on consecutive cycles.
  task automatic send_word(input logic [W-1:0] w, input logic dr);
    for (int i = W - 1; i >= 0; i--) cycle(1'b0, 1'b0, 1'b1, w[i], dr);
  endtask

  initial begin
    logic [W-1:0] w;
    clk = 0; rst = 0; clr = 0; sin = 0; sin_valid = 0; dout_ready = 0;
    n_total = 0; n_bad = 0;
    m_n = 0; acc_m = 0; acc_l = 0; md_m = 0; md_l = 0; m_valid = 0; m_known = 0;
    vcount = 0; stall_count = 0;
    @(negedge clk);

    // Reset with random side inputs.
    cycle(1'b1, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
    check_eq("rst_dout", dout_m, 8'h00);
    check_eq("rst_valid", dout_valid_m, 1'b0);
    check_eq("rst_ready", sin_ready_m, 1'b1);
    check_eq("rst_busy", busy_m, 1'b0);

    // Single word, then hold with idle inputs (sin undriven).
    send_word(8'hA5, 1'b0);
    check_eq("single_m", dout_m, 8'hA5);
    check_eq("single_l", dout_l, 8'hA5);
    check_eq("single_valid", dout_valid_m, 1'b1);
    repeat (5) cycle(1'b0, 1'b0, 1'b0, 1'bx, 1'b0);
    check_eq("hold_m", dout_m, 8'hA5);
    check_eq("hold_valid", dout_valid_m, 1'b1);

    // Back-pressure on the final bit of 3C.
    w = 8'h3C;
    for (int i = W - 1; i >= 1; i--) cycle(1'b0, 1'b0, 1'b1, w[i], 1'b0);
    cycle(1'b0, 1'b0, 1'b1, w[0], 1'b0);
    check_eq("bp_stall", obs_ready, 1'b0);
    check_eq("bp_held", dout_m, 8'hA5);
    cycle(1'b0, 1'b0, 1'b1, w[0], 1'b1);
    check_eq("bp_accept", last_acc, 1'b1);
    check_eq("bp_word", dout_m, 8'h3C);
    check_eq("bp_valid", dout_valid_m, 1'b1);

    // Continuous streaming: held 3C plus three words, each visible for one cycle.
    vcount = 0; stall_count = 0;
    send_word(8'hFF, 1'b1);
    send_word(8'h00, 1'b1);
    send_word(8'h81, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'bx, 1'b1);
    check_eq("stream_words", vcount, 4);
    check_eq("stream_stalls", stall_count, 0);

    // clr mid-word with a bit offered.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("clr_busy", busy_m, 1'b0);
    send_word(8'h5A, 1'b0);
    check_eq("clr_word", dout_m, 8'h5A);
    // clr while a word is held and handed off in the same cycle.
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("clr_handoff_valid", dout_valid_m, 1'b0);
    check_eq("clr_handoff_busy", busy_m, 1'b0);
    check_eq("clr_handoff_dout", dout_m, 8'h5A);

    // LSB-first ordering and mid-word reset.
    send_word(8'hA5, 1'b0);
    check_eq("lsb_word", dout_l, 8'hA5);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'($urandom), 1'b0);
    cycle(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    check_eq("midrst_valid", dout_valid_l, 1'b0);
    check_eq("midrst_busy", busy_l, 1'b0);
    check_eq("midrst_dout", dout_l, 8'h00);
    send_word(8'h96, 1'b0);
    check_eq("fresh_m", dout_m, 8'h96);
    check_eq("fresh_l", dout_l, 8'h69);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      logic r, c, v, s, dr;
      r  = ($urandom % 64) == 0;
      c  = ($urandom % 16) == 0;
      v  = ($urandom % 4) != 0;
      s  = v ? 1'($urandom) : 1'bx;
      dr = 1'($urandom);
      cycle(r, c, v, s, dr);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ser_word_collector.md
Name: ser_word_collector

Overview:
- Downstream neighbour of the mux-select DFF stage: it takes that stage's registered serial bit `q` and packs successive bits into WIDTH-bit words.
- Handshakes serial bits in (valid/ready) and words out (valid/ready), with back-pressure toward the bit source.
- Used wherever a single-bit registered stream must be presented as parallel data to a word-wide consumer.

Parameters:
- WIDTH, 8, bits per output word; legal range 2..32.
- MSB_FIRST, 1, 1: first received bit lands in dout[WIDTH-1]; 0: first received bit lands in dout[0].
- CNT_W, 5, bit-counter width; must satisfy 2**CNT_W >= WIDTH.

Ports:
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  synchronous, active-high reset; clears all state
- clr  input  1  synchronous abort: discards the partially collected word and leaves the output register untouched
- sin  input  1  serial data bit, driven from the upstream DFF `q`
- sin_valid  input  1  sin carries a bit this cycle
- sin_ready  output  1  collector can accept a bit this cycle
- dout  output  WIDTH  assembled word
- dout_valid  output  1  dout holds an unconsumed word
- dout_ready  input  1  consumer accepts dout this cycle
- busy  output  1  partial word in progress (bit count != 0)

Behaviour:
- Reset (rst=1 at posedge) forces: sr=0, cnt=0, dout=0, dout_valid=0. Combinationally this gives sin_ready=1 and busy=0. rst overrides every other input.
- Bit accept: an accept occurs when sin_valid && sin_ready at a posedge.
- MSB_FIRST=1: sr <= {sr[WIDTH-2:0], sin}. MSB_FIRST=0: sr <= {sin, sr[WIDTH-1:1]}.
- cnt counts 0..WIDTH-1 and increments on each accept.
- Word complete: an accept with cnt==WIDTH-1.
  - dout loads the fully shifted value, including the current bit.
  - dout_valid <= 1 and cnt <= 0.
  - Latency: the word is visible on dout the cycle after its last bit is accepted.
- Output register, two states:
  - EMPTY (dout_valid=0) goes to FULL on word complete.
  - FULL goes to EMPTY on dout_ready with no word complete in the same cycle.
  - FULL stays FULL, with dout reloaded, when dout_ready and word complete occur in the same cycle (back-to-back words, no bubble).
- sin_ready = !(cnt==WIDTH-1 && dout_valid && !dout_ready).
  - Stall only when the final bit would overwrite an unconsumed word.
  - Bits 0..WIDTH-2 of the next word are always accepted while a word is held.
- dout and dout_valid hold stable while dout_valid && !dout_ready.
- dout_ready while dout_valid=0 is ignored.
- sin_valid=0 means no shift and no count change. sin is don't-care (X-tolerant) when sin_valid=0.
- clr=1:
  - cnt <= 0 and sr <= 0.
  - Any bit offered that cycle is discarded.
  - dout and dout_valid are unaffected, and a concurrent dout_ready handshake still completes.
- busy = (cnt != 0), combinational from the registered count.
- Reset mid-word or mid-hold: all state is lost. No partial word is emitted.
- dout is never X after reset, including when X bits were presented with sin_valid=0.

Decomposition:
- Shared package/header holds:
  - Default WIDTH and the CNT_W sizing rule, which other serial-path blocks reuse.
  - The EMPTY/FULL state encodings (1'b0/1'b1).
- One natural sub-module: ser_bit_counter.
  - Mod-WIDTH counter with inc, clr, rst.
  - Outputs cnt and last (cnt==WIDTH-1).
- Shift register and output register stay in the top module.

Test Plan (WIDTH=8, MSB_FIRST=1 unless stated):
- Reset check: hold rst for 1 cycle with random sin/sin_valid -> after posedge + hold, dout=8'h00, dout_valid=0, sin_ready=1, busy=0.
- Single word: bits 1,0,1,0,0,1,0,1 on consecutive cycles with dout_ready=0 -> dout=8'hA5 and dout_valid=1 one cycle after the 8th bit; the word holds for 5 idle cycles.
- Back-pressure: hold 8'hA5 with dout_ready=0 and stream 8'h3C.
  - 7 bits accepted; sin_ready=0 while the 8th bit is offered.
  - Assert dout_ready -> 8'hA5 consumed and the 8th bit accepted the same cycle.
  - Next cycle dout=8'h3C, dout_valid=1, with no lost or duplicated bit.
- Continuous streaming: dout_ready=1 constantly, words 8'hFF, 8'h00, 8'h81 -> each word valid for exactly one cycle, every 8 cycles, sin_ready always 1.
- clr mid-word: 3 bits of 8'hF0, then clr=1 with sin_valid=1, then a full 8'h5A -> busy=0 after clr and the next word out is 8'h5A. Repeat with a held word and dout_ready asserted during clr -> the held word is still handed off.
- LSB-first and mid-word reset (MSB_FIRST=0): bits 1,0,1,0,0,1,0,1 -> dout=8'hA5. Then 4 bits followed by rst -> dout_valid=0 and busy=0; a fresh 8 bits produce a correct word.
